// File: rtl/iterative_alu_pkg.sv
// iterative_alu_pkg: shared ALU definitions (the alu_defs set) used by the ALU control decoder and the iterative ALU.
// Holds the 4-bit opcode values, the FSM state encoding and a small opcode-class helper.
package iterative_alu_pkg;
  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_NOR     = 4'b0010;
  localparam logic [3:0] ALU_ADD     = 4'b0011;
  localparam logic [3:0] ALU_SLL     = 4'b0101;
  localparam logic [3:0] ALU_SRL     = 4'b0110;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1001;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;
  function automatic logic is_shift(input logic [3:0] op);
    return op == ALU_SLL || op == ALU_SRL;
  endfunction
endpackage

// File: rtl/iterative_alu_if.sv
// iterative_alu_if: request/response bundle between a datapath controller and the iterative ALU.
// master (controller) drives in_valid, alu_operation, operand_a, operand_b, shamt;
// slave (ALU) drives in_ready, result, zero, illegal_op, done.
interface iterative_alu_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         alu_operation;
  logic [WIDTH-1:0]   operand_a;
  logic [WIDTH-1:0]   operand_b;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   result;
  logic               zero;
  logic               illegal_op;
  logic               done;
  modport master (
    output in_valid, alu_operation, operand_a, operand_b, shamt,
    input  in_ready, result, zero, illegal_op, done
  );
  modport slave (
    input  in_valid, alu_operation, operand_a, operand_b, shamt,
    output in_ready, result, zero, illegal_op, done
  );
endinterface

// File: rtl/iterative_alu_comb_unit.sv
// alu_comb_unit: combinational AND/OR/NOR/ADD plus illegal-opcode detection.
// Ports: i_op opcode, i_a/i_b operands, o_result (0 for shifts and illegal opcodes), o_illegal.
module alu_comb_unit
  import iterative_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_illegal
);
  always_comb begin
    o_result  = i_op == ALU_AND ? i_a & i_b :
                i_op == ALU_OR  ? i_a | i_b :
                i_op == ALU_NOR ? ~(i_a | i_b) :
                i_op == ALU_ADD ? i_a + i_b : '0;
    o_illegal = !(i_op inside {ALU_AND, ALU_OR, ALU_NOR, ALU_ADD, ALU_SLL, ALU_SRL});
  end
endmodule

// File: rtl/iterative_alu.sv
// iterative_alu: valid/ready ALU with single-cycle logic/add ops and bit-serial SLL/SRL.
// Ports: clk, reset (sync, active-high), bus (iterative_alu_if.slave: request in, result/zero/illegal_op/done out).
// Build option: define ALU_FAST_SHIFT_EN to replace the bit-serial shifter with a barrel shifter (1-cycle shifts).
module iterative_alu
  import iterative_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  iterative_alu_if.slave       bus
);
  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_sh, r_result, w_comb, w_fast, w_step, w_imm;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_left, r_zero, r_illegal;
  logic               w_illegal, w_accept, w_go_shift, w_last;
  alu_comb_unit #(.WIDTH(WIDTH)) u_comb (
    .i_op      (bus.alu_operation),
    .i_a       (bus.operand_a),
    .i_b       (bus.operand_b),
    .o_result  (w_comb),
    .o_illegal (w_illegal)
  );
`ifdef ALU_FAST_SHIFT_EN
  assign w_fast     = bus.alu_operation == ALU_SLL ? bus.operand_b << bus.shamt : bus.operand_b >> bus.shamt;
  assign w_go_shift = 1'b0;
`else
  // Only a zero-amount shift completes immediately; its result is the unshifted operand.
  assign w_fast     = bus.operand_b;
  assign w_go_shift = is_shift(bus.alu_operation) && |bus.shamt;
`endif
  assign w_accept = bus.in_valid && r_state == S_IDLE;
  assign w_step   = r_left ? r_sh << 1 : r_sh >> 1;
  assign w_last   = r_cnt == SHAMT_W'(1);
  assign w_imm    = is_shift(bus.alu_operation) ? w_fast : w_comb;
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = w_accept ? (w_go_shift ? S_SHIFT : S_DONE) : S_IDLE;
      S_SHIFT: w_next = w_last ? S_DONE : S_SHIFT;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    bus.in_ready   = r_state == S_IDLE;
    bus.done       = r_state == S_DONE;
    bus.result     = r_result;
    bus.zero       = r_zero;
    bus.illegal_op = r_illegal;
  end
  // Result registers load only on the edge that enters DONE, so they hold steady otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh      <= '0;
      r_cnt     <= '0;
      r_left    <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_sh   <= bus.operand_b;
      r_cnt  <= bus.shamt;
      r_left <= bus.alu_operation == ALU_SLL;
      if (!w_go_shift) begin
        r_result  <= w_imm;
        r_zero    <= w_imm == '0;
        r_illegal <= w_illegal;
      end
    end else if (r_state == S_SHIFT) begin
      r_sh  <= w_step;
      r_cnt <= r_cnt - SHAMT_W'(1);
      if (w_last) begin
        r_result  <= w_step;
        r_zero    <= w_step == '0;
        r_illegal <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_iterative_alu.sv
// tb_iterative_alu: directed + random self-checking bench for iterative_alu against a behavioural model.
module tb_iterative_alu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  iterative_alu_if #(.WIDTH(32), .SHAMT_W(5)) bus ();
  iterative_alu #(.WIDTH(32), .SHAMT_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int sh);
    case (op)
      4'd0:    return {1'b0, a & b};
      4'd1:    return {1'b0, a | b};
      4'd2:    return {1'b0, ~(a | b)};
      4'd3:    return {1'b0, a + b};
      4'd5:    return sh >= 32 ? 33'd0 : {1'b0, b << sh};
      4'd6:    return sh >= 32 ? 33'd0 : {1'b0, b >> sh};
      default: return {1'b1, 32'd0};
    endcase
  endfunction
  function automatic int ref_lat(input logic [3:0] op, input int sh);
    return (!FAST && (op == 4'd5 || op == 4'd6) && sh > 0) ? sh + 1 : 1;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    logic [32:0] exp;
    logic [31:0] prev;
    int lat, n;
    bit stable;
    exp = ref_alu(op, a, b, int'(sh));
    lat = ref_lat(op, int'(sh));
    @(negedge clk);
    check("ready_idle", 32'(bus.in_ready), 32'd1);
    prev = bus.result;
    bus.alu_operation = op;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.shamt = sh;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
    bus.shamt = 5'($urandom);
    bus.alu_operation = 4'($urandom);
    n = 0;
    stable = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (!bus.done && (bus.result !== prev || bus.in_ready !== 1'b0)) stable = 1'b0;
    end while (!bus.done && n < 100);
    check($sformatf("latency op%0h", op), 32'(n), 32'(lat));
    check("done_pulse", 32'(bus.done), 32'd1);
    check("ready_busy", 32'(bus.in_ready), 32'd0);
    check($sformatf("result op%0h", op), bus.result, exp[31:0]);
    check("zero", 32'(bus.zero), 32'(exp[31:0] == 32'd0));
    check("illegal_op", 32'(bus.illegal_op), 32'(exp[32]));
    check("stable_while_busy", 32'(stable), 32'd1);
  endtask
  task automatic check_reset_state();
    check("rst_result", bus.result, 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd1);
    check("rst_illegal", 32'(bus.illegal_op), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
  endtask
  initial begin
    logic [3:0] ops [8];
    bit ok;
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd9, 4'd12};
    bus.in_valid = 1'b0;
    bus.alu_operation = 4'd0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.shamt = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_state();
    run_op(4'd3, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
    run_op(4'd2, 32'h0F0F_0000, 32'h0000_0F0F, 5'd0);
    run_op(4'd0, 32'h0F0F_0000, 32'h0000_0F0F, 5'd0);
    run_op(4'd5, 32'h0, 32'h0000_0003, 5'd4);
    run_op(4'd6, 32'h0, 32'h8000_0000, 5'd31);
    run_op(4'd9, 32'h1234_5678, 32'h1234_5678, 5'd0);
    run_op(4'd1, 32'h1, 32'h2, 5'd0);
    run_op(4'd5, 32'h0, 32'hDEAD_BEEF, 5'd0);
    run_op(4'd6, 32'h0, 32'hF000_0000, 5'd8);
    run_op(4'd5, 32'h0, 32'hFFFF_FFFF, 5'd1);
    for (int i = 0; i < 30; i++)
      run_op(ops[$urandom_range(0, 7)], $urandom, $urandom, 5'($urandom));
    run_op(4'd1, 32'h00A0_0000, 32'h0000_0005, 5'd0);
`ifndef ALU_FAST_SHIFT_EN
    @(negedge clk);
    bus.alu_operation = 4'd5;
    bus.operand_b = 32'h0000_0001;
    bus.shamt = 5'd20;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    ok = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 3) begin
        bus.alu_operation = 4'd3;
        bus.operand_a = 32'd1;
        bus.operand_b = 32'd1;
        bus.shamt = 5'd0;
        bus.in_valid = 1'b1;
      end
      if (c == 5) bus.in_valid = 1'b0;
      if (bus.in_ready !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h00A0_0005) ok = 1'b0;
    end
    check("ignored_while_shifting", 32'(ok), 32'd1);
`endif
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_state();
    ok = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.in_ready !== 1'b1) ok = 1'b0;
    end
    check("no_done_after_reset", 32'(ok), 32'd1);
    run_op(4'd3, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
